// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg: shared state encoding and ACK/NACK bit values for the I2C target
package i2c_slave_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } i2c_slv_state_e;
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_slave_sync.sv
// i2c_slave_sync: pad synchronizers plus SCL edge and START/STOP detection
module i2c_slave_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o,
  output logic sda_s_o
);
  logic [1:0] scl_sq, sda_sq;
  logic       scl_dq, sda_dq;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sq <= 2'b11;
      sda_sq <= 2'b11;
      scl_dq <= 1'b1;
      sda_dq <= 1'b1;
    end else begin
      scl_sq <= {scl_sq[0], scl_i};
      sda_sq <= {sda_sq[0], sda_i};
      scl_dq <= scl_sq[1];
      sda_dq <= sda_sq[1];
    end
  end
  assign sda_s_o     = sda_sq[1];
  assign scl_rise_o  = scl_sq[1] & ~scl_dq;
  assign scl_fall_o  = ~scl_sq[1] & scl_dq;
  assign start_det_o = scl_sq[1] & scl_dq & ~sda_sq[1] & sda_dq;
  assign stop_det_o  = scl_sq[1] & scl_dq & sda_sq[1] & ~sda_dq;
endmodule

// File: rtl/i2c_slave_mem.sv
// i2c_slave_mem: I2C target with EEPROM-style pointer/data writes and sequential reads
module i2c_slave_mem
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] ADDRESS = 7'b1010_000,
  parameter int         DEPTH   = 256,
  localparam int        AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scl_pad_i,
  input  logic          sda_pad_i,
  output logic          sda_pad_o,
  output logic          sda_padoen_o,
  input  logic [AW-1:0] reg_addr_i,
  output logic [7:0]    reg_rdata_o,
  output logic          wr_valid_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [7:0]    wr_data_o,
  output logic          busy_o
);
  i2c_slv_state_e state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [7:0]     sh_q, sh_d, rx_byte;
  logic [AW-1:0]  ptr_q, ptr_d;
  logic           oen_q, oen_d, rw_q, rw_d, busy_q, busy_d, we;
  logic [7:0]     mem_q [DEPTH];
  logic           scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_slave_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl_pad_i),
    .sda_i      (sda_pad_i),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_det_o(start_det),
    .stop_det_o (stop_det),
    .sda_s_o    (sda_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    oen_d   = oen_q;
    rw_d    = rw_q;
    busy_d  = busy_q;
    we      = 1'b0;
    rx_byte = {sh_q[6:0], sda_s};
    if (start_det) begin
      state_d = S_ADDR;
      cnt_d   = 3'd0;
      oen_d   = 1'b1;
      busy_d  = 1'b0;
    end else if (stop_det) begin
      state_d = S_IDLE;
      oen_d   = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WR_DATA: if (scl_rise) begin
          sh_d  = rx_byte;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (state_q == S_ADDR) begin
              state_d = (sh_q[6:0] == ADDRESS) ? S_ADDR_ACK : S_IGNORE;
              busy_d  = (sh_q[6:0] == ADDRESS);
              rw_d    = sda_s;
            end else if (state_q == S_PTR) begin
              ptr_d   = rx_byte[AW-1:0];
              state_d = S_PTR_ACK;
            end else begin
              we      = 1'b1;
              ptr_d   = ptr_q + AW'(1);
              state_d = S_WR_ACK;
            end
          end
        end
        // first fall drives the ACK, the following fall releases it and moves on
        S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: if (scl_fall) begin
          if (oen_q) oen_d = ACK;
          else if (state_q == S_ADDR_ACK && rw_q) begin
            state_d = S_RD_DATA;
            sh_d    = mem_q[ptr_q];
            oen_d   = mem_q[ptr_q][7];
          end else begin
            oen_d   = 1'b1;
            state_d = (state_q == S_ADDR_ACK) ? S_PTR : S_WR_DATA;
          end
        end
        S_RD_DATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            sh_d  = {sh_q[6:0], 1'b0};
          end else if (scl_fall) begin
            oen_d   = (cnt_q == 3'd0) ? 1'b1 : sh_q[7];
            ptr_d   = (cnt_q == 3'd0) ? ptr_q + AW'(1) : ptr_q;
            state_d = (cnt_q == 3'd0) ? S_RD_ACK : S_RD_DATA;
          end
        end
        S_RD_ACK: begin
          if (scl_rise && sda_s == NACK) state_d = S_IGNORE;
          else if (scl_fall) begin
            state_d = S_RD_DATA;
            sh_d    = mem_q[ptr_q];
            oen_d   = mem_q[ptr_q][7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      sh_q    <= 8'h00;
      ptr_q   <= '0;
      oen_q   <= 1'b1;
      rw_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      oen_q   <= oen_d;
      rw_q    <= rw_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      wr_valid_o <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= 8'h00;
    end else begin
      wr_valid_o <= we;
      if (we) begin
        mem_q[ptr_q] <= rx_byte;
        wr_addr_o    <= ptr_q;
        wr_data_o    <= rx_byte;
      end
    end
  end

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = oen_q;
  assign busy_o       = busy_q;
  assign reg_rdata_o  = mem_q[reg_addr_i];
endmodule

// File: doc/i2c_slave_mem.md
# i2c_slave_mem

Synthesizable I2C target (slave) with an internal byte-addressed register memory. It is the responder counterpart of the SoC's I2C master, and is used on FPGA/emulation boards and in system benches in place of an external EEPROM. It answers a single 7-bit address and implements EEPROM-style pointer-then-data writes and sequential reads. It also exposes a host-side read port and a write-event strobe for local logic.

## Interface
- `ADDRESS`, default `7'b1010_000`: 7-bit target address answered.
- `DEPTH`, default `256`: memory bytes; power of two, 2..256. `AW = $clog2(DEPTH)` is a derived localparam.
- `clk` in 1: system clock; must be ≥ 10× the SCL frequency.
- `rst_n` in 1: reset, asynchronous, active-low.
- `scl_pad_i` in 1: SCL pad input.
- `sda_pad_i` in 1: SDA pad input.
- `sda_pad_o` out 1: constant 0 (open-drain).
- `sda_padoen_o` out 1: SDA output enable, active-low; 0 pulls SDA low. Reset value 1.
- `reg_addr_i` in AW: host read address.
- `reg_rdata_o` out 8: `mem[reg_addr_i]`, combinational.
- `wr_valid_o` out 1: one-cycle pulse per byte written from I2C. Reset value 0.
- `wr_addr_o` out AW: address of the written byte. Reset value 0.
- `wr_data_o` out 8: written byte value. Reset value 0.
- `busy_o` out 1: 1 while addressed (ADDR_ACK through the end of the transfer). Reset value 0.

## Operation
- SCL and SDA each pass through a 2-flop synchronizer, then a delay flop for edge detection.
- START: synced SDA falls while synced SCL is high. STOP: synced SDA rises while synced SCL is high.
- Data bits are sampled on synced SCL rising edges, MSB first. The target changes SDA only on synced SCL falling edges.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- START in any state: clear the bit counter and go to ADDR. This covers repeated START.
- STOP in any state: go to IDLE, release SDA, set `busy_o` to 0.
- IDLE: wait for START.
- ADDR: shift 8 bits.
  - Address mismatch: go to IGNORE and never drive SDA.
  - Match: go to ADDR_ACK.
- ADDR_ACK: pull SDA low for the 9th clock. Then:
  - R/W = 0: go to PTR.
  - R/W = 1: go to RD_DATA, starting from the current pointer.
- PTR: 8 bits; pointer ← byte[AW-1:0]. Then PTR_ACK (ACK), then WR_DATA.
- WR_DATA: 8 bits; `mem[ptr]` ← byte; pulse `wr_valid_o`; ptr ← ptr+1 mod DEPTH. Then WR_ACK (ACK), then WR_DATA.
- RD_DATA: drive `mem[ptr]` MSB first. A 1 bit releases SDA and a 0 bit pulls it low. After the 8th bit: ptr+1 mod DEPTH, release SDA, go to RD_ACK.
- RD_ACK: sample the master bit on SCL rising edge.
  - 0 (ACK): go to RD_DATA.
  - 1 (NACK): go to IGNORE until STOP or START.
- The pointer persists across transactions and is reset to 0.
- Memory is reset to `8'h00`.
- Simultaneous host read and I2C write to the same address: `reg_rdata_o` shows the old value until the write edge.

## Timing
- Pad-to-internal detection latency: 3 clk.
- ACK/data drive: `sda_padoen_o` updates 1 clk after falling-edge detection. It is held through the SCL high phase and released 1 clk after the next falling-edge detection.
- `wr_valid_o` asserts 1 clk after the 8th rising edge of a data byte. `wr_addr_o` and `wr_data_o` are valid in that same cycle and held until the next write.
- STOP mid-byte: the partial byte is discarded, with no write and no pointer change.
- START is never detected while the target is driving SDA, because the target drives only while SCL is low.
- Reset mid-transfer: all outputs return to their reset values asynchronously, the state machine goes to IDLE, and the memory clears.

## Structure
- `i2c_slave_pkg` holds the state enum `i2c_slv_state_e` and the `ACK = 1'b0` / `NACK = 1'b1` constants.
- Sub-module `i2c_slave_sync` holds the synchronizers and edge/START/STOP detection. It outputs `scl_rise`, `scl_fall`, `start_det`, `stop_det` and `sda_s`.
- The top level holds the FSM, bit counter, shift register, pointer and memory array.

## Test plan
- Write: START, `0xA0`, `0x10`, `0xA5`, `0x3C`, STOP.
  - Required: four ACKs.
  - Required: `mem[0x10]=0xA5`, `mem[0x11]=0x3C`.
  - Required: two `wr_valid_o` pulses.
- Random read: START, `0xA0`, `0x10`, Sr, `0xA1`, read 2 bytes with ACK then NACK, STOP.
  - Required: data `0xA5`, `0x3C`.
  - Required: `sda_padoen_o=1` after NACK.
- Address mismatch: START, `0xA2`, `0x00`, `0xFF`, STOP.
  - Required: the 9th bit is NACK and SDA is never driven.
  - Required: memory unchanged, `busy_o` stays 0.
- Wrap-around (DEPTH=256): write from pointer `0xFF` with bytes `0x11`, `0x22`.
  - Required: `mem[0xFF]=0x11`, `mem[0x00]=0x22`.
- STOP after 4 bits of a data byte.
  - Required: no write, pointer unchanged, state IDLE.
  - Required: the next transaction behaves normally.
- Assert `rst_n` during RD_DATA while SDA is driven low.
  - Required: `sda_padoen_o=1` with no clk edge needed.
  - Required: `mem[0x10]=0x00` afterwards.
